// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - arbitrates GP-register write bus among NUM_REQ requesters
//
// Purpose: grants one requester at a time access to the register-bank write bus
//          (read_or_write select + write_data), one write per req/ack handshake.
//          Transaction: IDLE -> DRIVE (write_strobe) -> ACK (ack pulse) -> IDLE.
// Ports:
//   clock          system clock, all state on posedge
//   reset          asynchronous, active-low
//   req            per-requester write request, held until its ack
//   req_sel        per-requester target select code (slice i = requester i)
//   req_data       per-requester write value (slice i = requester i)
//   ack            one-cycle one-hot completion pulse to the winner
//   read_or_write  select code to the register bank (IDLE_SEL when no write)
//   write_data     data to the register bank
//   write_strobe   high for the single cycle the bus carries a valid write
//   busy           high whenever the arbiter is not idle
//   conflict_cnt   saturating count of grants made with more than one req pending
// Configuration:
//   REGWR_FIXED_PRIO_EN  defined: fixed priority, lowest index wins
//                        undefined: round-robin starting after the last winner

module regwrite_arbiter #(
    parameter int                NUM_REQ  = 3,
    parameter int                DATA_W   = 32,
    parameter int                SEL_W    = 4,
    parameter logic [SEL_W-1:0]  IDLE_SEL = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [SEL_W-1:0]           read_or_write,
    output logic [DATA_W-1:0]          write_data,
    output logic                       write_strobe,
    output logic                       busy,
    output logic [7:0]                 conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [PTR_W-1:0]     grant_q, grant_next;
    logic [NUM_REQ-1:0]   ack_next;
    logic [SEL_W-1:0]     rw_next;
    logic [DATA_W-1:0]    wd_next;
    logic                 strobe_next;
    logic                 busy_next;
    logic [7:0]           cnt_next;
    logic                 found;
    logic [PTR_W-1:0]     win;
    logic [SEL_W-1:0]     win_sel;
`ifndef REGWR_FIXED_PRIO_EN
    logic [PTR_W-1:0]     ptr, ptr_next;
    int                   rr_idx;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            grant_q       <= '0;
            ack           <= '0;
            read_or_write <= IDLE_SEL;
            write_data    <= '0;
            write_strobe  <= 1'b0;
            busy          <= 1'b0;
            conflict_cnt  <= 8'd0;
`ifndef REGWR_FIXED_PRIO_EN
            // Last winner = NUM_REQ-1 so requester 0 is searched first.
            ptr           <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            state         <= state_next;
            grant_q       <= grant_next;
            ack           <= ack_next;
            read_or_write <= rw_next;
            write_data    <= wd_next;
            write_strobe  <= strobe_next;
            busy          <= busy_next;
            conflict_cnt  <= cnt_next;
`ifndef REGWR_FIXED_PRIO_EN
            ptr           <= ptr_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant_q;
        ack_next    = '0;
        rw_next     = IDLE_SEL;
        wd_next     = write_data;
        strobe_next = 1'b0;
        cnt_next    = conflict_cnt;
        found       = 1'b0;
        win         = '0;
`ifdef REGWR_FIXED_PRIO_EN
        // Scan high to low so the lowest requesting index is the last assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
`else
        ptr_next = ptr;
        rr_idx   = 0;
        // Search starts one past the previous winner and wraps.
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_idx = int'(ptr) + i;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                win   = PTR_W'(rr_idx);
            end
        end
`endif
        win_sel = req_sel[win*SEL_W +: SEL_W];

        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_next = ST_DRIVE;
                    grant_next = win;
                    rw_next    = win_sel;
                    wd_next    = req_data[win*DATA_W +: DATA_W];
                    // A select of IDLE_SEL is a no-op: the bank sees no strobe.
                    strobe_next = (win_sel != IDLE_SEL);
`ifndef REGWR_FIXED_PRIO_EN
                    ptr_next = win;
`endif
                    if (($countones(req) > 1) && (conflict_cnt != 8'hFF))
                        cnt_next = conflict_cnt + 8'd1;
                end
            end
            ST_DRIVE: begin
                state_next         = ST_ACK;
                ack_next[grant_q]  = 1'b1;
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - directed self-checking bench for regwrite_arbiter

module tb_regwrite_arbiter;

    logic         clock;
    logic         reset;
    logic [2:0]   req;
    logic [11:0]  req_sel;
    logic [95:0]  req_data;
    logic [2:0]   ack;
    logic [3:0]   read_or_write;
    logic [31:0]  write_data;
    logic         write_strobe;
    logic         busy;
    logic [7:0]   conflict_cnt;

    int checks   = 0;
    int failures = 0;

    regwrite_arbiter #(
        .NUM_REQ  (3),
        .DATA_W   (32),
        .SEL_W    (4),
        .IDLE_SEL (4'h0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_sel       (req_sel),
        .req_data      (req_data),
        .ack           (ack),
        .read_or_write (read_or_write),
        .write_data    (write_data),
        .write_strobe  (write_strobe),
        .busy          (busy),
        .conflict_cnt  (conflict_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [2:0] exp_ack [4];
    logic [3:0] exp_sel [4];

    initial begin
        reset    = 1'b1;
        req      = 3'b000;
        req_sel  = '0;
        req_data = '0;
        #2;

        // 1: reset asserted with all requests pending
        reset = 1'b0;
        req   = 3'b111;
        req_sel  = {4'h7, 4'h3, 4'h6};
        tick();
        tick();
        check_val("rst_ack",    ack,           3'b000);
        check_val("rst_rw",     read_or_write, 4'h0);
        check_val("rst_wd",     write_data,    32'h0);
        check_val("rst_strobe", write_strobe,  1'b0);
        check_val("rst_busy",   busy,          1'b0);
        check_val("rst_cnt",    conflict_cnt,  8'h00);
        req   = 3'b000;
        tick();
        reset = 1'b1;

        // 2: single write from req0
        req_sel[3:0]   = 4'h6;
        req_data[31:0] = 32'h0000_1234;
        req = 3'b001;
        tick();
        check_val("t2_strobe", write_strobe,  1'b1);
        check_val("t2_rw",     read_or_write, 4'h6);
        check_val("t2_wd",     write_data,    32'h0000_1234);
        check_val("t2_busy",   busy,          1'b1);
        tick();
        check_val("t2_ack",     ack,           3'b001);
        check_val("t2_rw_ack",  read_or_write, 4'h0);
        check_val("t2_strb_ack", write_strobe, 1'b0);
        check_val("t2_wd_hold", write_data,    32'h0000_1234);
        req = 3'b000;
        tick();
        check_val("t2_idle",   busy,          1'b0);
        check_val("t2_ack0",   ack,           3'b000);
        check_val("t2_cnt",    conflict_cnt,  8'h00);

        // 3: all three held, fresh pointer
        do_reset();
`ifdef REGWR_FIXED_PRIO_EN
        exp_ack = '{3'b001, 3'b001, 3'b001, 3'b001};
        exp_sel = '{4'h6, 4'h6, 4'h6, 4'h6};
`else
        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_sel = '{4'h6, 4'h3, 4'h7, 4'h6};
`endif
        req_sel  = {4'h7, 4'h3, 4'h6};
        req_data = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            tick();
            check_val($sformatf("t3_strobe%0d", g), write_strobe,  1'b1);
            check_val($sformatf("t3_rw%0d", g),     read_or_write, exp_sel[g]);
            tick();
            check_val($sformatf("t3_ack%0d", g),    ack,           exp_ack[g]);
            if (g == 3) req = 3'b000;
            tick();
        end
        check_val("t3_cnt",  conflict_cnt, 8'd4);
        check_val("t3_busy", busy,         1'b0);

        // 4: no-op write (select equals idle code)
        req_sel[7:4] = 4'h0;
        req = 3'b010;
        tick();
        check_val("t4_strobe", write_strobe,  1'b0);
        check_val("t4_rw",     read_or_write, 4'h0);
        check_val("t4_busy",   busy,          1'b1);
        tick();
        check_val("t4_ack",    ack,           3'b010);
        check_val("t4_strb2",  write_strobe,  1'b0);
        req = 3'b000;
        tick();
        check_val("t4_idle",   busy,          1'b0);
        check_val("t4_cnt",    conflict_cnt,  8'd4);

        // 5: req2 drops and data changes during DRIVE
        req_sel[11:8]   = 4'h5;
        req_data[95:64] = 32'hAAAA_5555;
        req = 3'b100;
        tick();
        check_val("t5_strobe", write_strobe, 1'b1);
        check_val("t5_wd",     write_data,   32'hAAAA_5555);
        req = 3'b000;
        req_data[95:64] = 32'h0000_DEAD;
        req_sel[11:8]   = 4'h9;
        tick();
        check_val("t5_ack",    ack,          3'b100);
        check_val("t5_wd_ack", write_data,   32'hAAAA_5555);
        tick();
        check_val("t5_idle",   busy,         1'b0);
        check_val("t5_ack0",   ack,          3'b000);

        // 6: reset during DRIVE aborts the write
        req_sel[3:0]   = 4'h6;
        req_data[31:0] = 32'h0000_0001;
        req = 3'b001;
        tick();
        check_val("t6_strobe", write_strobe, 1'b1);
        reset = 1'b0;
        #1;
        check_val("t6_rst_strobe", write_strobe,  1'b0);
        check_val("t6_rst_busy",   busy,          1'b0);
        check_val("t6_rst_rw",     read_or_write, 4'h0);
        req = 3'b101;
        tick();
        tick();
        check_val("t6_no_ack", ack, 3'b000);
        reset = 1'b1;
        tick();
        check_val("t6_re_strobe", write_strobe,  1'b1);
        check_val("t6_re_rw",     read_or_write, 4'h6);
        tick();
        check_val("t6_re_ack",    ack,           3'b001);
        check_val("t6_re_cnt",    conflict_cnt,  8'd1);

        // conflict counter saturation
        req = 3'b111;
        repeat (800) tick();
        check_val("sat_cnt", conflict_cnt, 8'hFF);
        req = 3'b000;
        repeat (4) tick();
        check_val("sat_hold", conflict_cnt, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
